// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants and helpers for the programmable sequence detector
package seq_det_pkg;

  localparam int          DEF_MAX_LEN     = 16;
  localparam logic [15:0] DEF_RST_PATTERN = 16'h0EDB;
  localparam int          DEF_RST_LEN     = 12;
  localparam int          MASK_MAX        = 64;

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Callers truncate the result to their own MAX_LEN width.
  function automatic logic [MASK_MAX-1:0] len_mask(input int len);
    logic [MASK_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_MAX; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_detector_prog_if.sv
// rtl/seq_detector_prog_if.sv - configuration, serial stream and result signals of the detector
interface seq_detector_prog_if
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = 8
);

  localparam int LEN_W = len_width(MAX_LEN);

  logic               cfg_load_i;
  logic [MAX_LEN-1:0] cfg_pattern_i;
  logic [LEN_W-1:0]   cfg_len_i;
  logic               cfg_overlap_i;
  logic               valid_i;
  logic               x_i;
  logic               clr_cnt_i;
  logic               det_o;
  logic               armed_o;
  logic [CNT_W-1:0]   hit_cnt_o;

  modport master (
    output cfg_load_i, cfg_pattern_i, cfg_len_i, cfg_overlap_i,
    output valid_i, x_i, clr_cnt_i,
    input  det_o, armed_o, hit_cnt_o
  );

  modport slave (
    input  cfg_load_i, cfg_pattern_i, cfg_len_i, cfg_overlap_i,
    input  valid_i, x_i, clr_cnt_i,
    output det_o, armed_o, hit_cnt_o
  );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter; a clear in the same cycle as an increment yields 1
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= inc ? W'(1) : '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_detector_prog.sv
// rtl/seq_detector_prog.sv - runtime-programmable serial bit-sequence detector
// Pattern is right-aligned: bit[len-1] is the oldest bit of a match, bit[0] the newest.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = DEF_MAX_LEN,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_RST_PATTERN),
  parameter int                 RST_LEN     = DEF_RST_LEN,
  parameter bit                 RST_OVERLAP = 1'b1
) (
  input logic                clk,
  input logic                reset,
  seq_detector_prog_if.slave bus
);

  localparam int LEN_W = len_width(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pattern_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [MAX_LEN-1:0] hist_d;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   fill_q;
  logic [LEN_W-1:0]   fill_d;
  logic [LEN_W-1:0]   cfg_len;
  logic               ovl_q;
  logic               det_q;
  logic               sample;
  logic               hit;
  logic [CNT_W-1:0]   hit_cnt;

  assign cfg_len = (bus.cfg_len_i > LEN_MAX) ? LEN_MAX : bus.cfg_len_i;
  assign mask    = MAX_LEN'(len_mask(int'(len_q)));

  // A load cycle takes priority over the stream; its data bit is dropped.
  assign sample = bus.valid_i && !bus.cfg_load_i;
  assign hist_d = {hist_q[MAX_LEN-2:0], bus.x_i};
  assign fill_d = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_W'(1);

  assign hit = sample
            && (len_q != '0)
            && (fill_d >= len_q)
            && (((hist_d ^ pattern_q) & mask) == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_q <= RST_PATTERN;
      len_q     <= LEN_W'(RST_LEN);
      ovl_q     <= RST_OVERLAP;
      hist_q    <= '0;
      fill_q    <= '0;
      det_q     <= 1'b0;
    end else if (bus.cfg_load_i) begin
      pattern_q <= bus.cfg_pattern_i;
      len_q     <= cfg_len;
      ovl_q     <= bus.cfg_overlap_i;
      hist_q    <= '0;
      fill_q    <= '0;
      det_q     <= 1'b0;
    end else if (sample) begin
      hist_q    <= hist_d;
      // Non-overlap mode restarts collection so the next match needs len fresh bits.
      fill_q    <= (hit && !ovl_q) ? '0 : fill_d;
      det_q     <= hit;
    end else begin
      det_q     <= 1'b0;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_hit_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit),
    .clr   (bus.clr_cnt_i),
    .cnt   (hit_cnt)
  );

  assign bus.det_o     = det_q;
  assign bus.armed_o   = (len_q != '0) && (fill_q >= len_q);
  assign bus.hit_cnt_o = hit_cnt;

endmodule

// File: tb/tb_seq_detector_prog.sv
// tb/tb_seq_detector_prog.sv - self-checking bench for seq_detector_prog against a queue-based model
module tb_seq_detector_prog;

  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = 3;

  logic clk;
  logic reset;

  seq_detector_prog_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int pulses     = 0;

  logic [15:0] pat_m;
  int          len_m;
  bit          ovl_m;
  bit          hist_m[$];
  int          cnt_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pat_m = 16'h0EDB;
    len_m = 12;
    ovl_m = 1'b1;
    hist_m.delete();
    cnt_m = 0;
  endtask

  function automatic bit model_armed();
    return (len_m != 0) && (hist_m.size() >= len_m);
  endfunction

  task automatic check_outputs(input string tag, input bit exp_det);
    check({tag, ".det"},   32'(bus.det_o),     32'(exp_det));
    check({tag, ".armed"}, 32'(bus.armed_o),   32'(model_armed()));
    check({tag, ".cnt"},   32'(bus.hit_cnt_o), 32'(cnt_m));
  endtask

  task automatic cycle(input bit v, input bit x, input bit clr);
    bit hit;
    @(negedge clk);
    bus.cfg_load_i = 1'b0;
    bus.valid_i    = v;
    bus.x_i        = x;
    bus.clr_cnt_i  = clr;
    hit = 1'b0;
    if (v) begin
      hist_m.push_back(x);
      if (hist_m.size() > MAX_LEN) void'(hist_m.pop_front());
      if (len_m != 0 && hist_m.size() >= len_m) begin
        hit = 1'b1;
        for (int k = 0; k < len_m; k++)
          if (hist_m[hist_m.size() - 1 - k] != pat_m[k]) hit = 1'b0;
      end
      if (hit && !ovl_m) hist_m.delete();
    end
    if (clr) cnt_m = hit ? 1 : 0;
    else if (hit && cnt_m < CNT_MAX) cnt_m++;
    @(posedge clk);
    #1;
    if (bus.det_o) pulses++;
    check_outputs("cycle", hit);
  endtask

  task automatic load(input logic [15:0] pat, input int len, input bit ovl);
    @(negedge clk);
    bus.cfg_load_i    = 1'b1;
    bus.cfg_pattern_i = pat;
    bus.cfg_len_i     = 5'(len);
    bus.cfg_overlap_i = ovl;
    bus.valid_i       = 1'($urandom_range(0, 1));
    bus.x_i           = 1'($urandom_range(0, 1));
    bus.clr_cnt_i     = 1'b0;
    pat_m = pat;
    len_m = (len > MAX_LEN) ? MAX_LEN : len;
    ovl_m = ovl;
    hist_m.delete();
    @(posedge clk);
    #1;
    check_outputs("load", 1'b0);
    pulses = 0;
  endtask

  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_reset", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
  endtask

  task automatic feed_bits(input logic [15:0] bits, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) cycle(1'b1, bits[i], 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    bus.cfg_load_i    = 1'b0;
    bus.cfg_pattern_i = '0;
    bus.cfg_len_i     = '0;
    bus.cfg_overlap_i = 1'b0;
    bus.valid_i       = 1'b0;
    bus.x_i           = 1'b0;
    bus.clr_cnt_i     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Default 12-bit pattern straight out of reset
    pulses = 0;
    feed_bits(16'h0EDB, 11, 0);
    check("default.pulses", 32'(pulses), 32'd1);
    check("default.cnt", 32'(bus.hit_cnt_o), 32'd1);
    cycle(1'b0, 1'b0, 1'b1);
    check("clr_alone.cnt", 32'(bus.hit_cnt_o), 32'd0);

    // Overlapping 1011 on 1011011
    load(16'h000B, 4, 1'b1);
    feed_bits(16'h005B, 6, 0);
    check("overlap.pulses", 32'(pulses), 32'd2);
    check("overlap.cnt", 32'(bus.hit_cnt_o), 32'd2);

    // Non-overlapping on the same stream
    cycle(1'b0, 1'b0, 1'b1);
    load(16'h000B, 4, 1'b0);
    feed_bits(16'h005B, 6, 3);
    check("nonovl.armed_after_hit", 32'(bus.armed_o), 32'd0);
    feed_bits(16'h005B, 2, 0);
    check("nonovl.pulses", 32'(pulses), 32'd1);
    check("nonovl.cnt", 32'(bus.hit_cnt_o), 32'd1);

    // 101 with idle gaps carrying toggling data
    load(16'h0005, 3, 1'b1);
    for (int i = 2; i >= 0; i--) begin
      cycle(1'b1, 1'(16'h0005 >> i), 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
    end
    check("gaps.pulses", 32'(pulses), 32'd1);

    // Length 0 disables detection
    load(16'hFFFF, 0, 1'b1);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    check("len0.pulses", 32'(pulses), 32'd0);

    // Saturation, then clear coincident with a hit
    load(16'h0003, 2, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0);
    check("sat.cnt", 32'(bus.hit_cnt_o), 32'd3);
    check("sat.pulses", 32'(pulses), 32'd9);
    cycle(1'b1, 1'b1, 1'b1);
    check("clr_hit.cnt", 32'(bus.hit_cnt_o), 32'd1);

    // Async reset after 8 of 12 bits
    load(16'h0003, 2, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    async_reset();
    feed_bits(16'h0EDB, 11, 4);
    async_reset();
    feed_bits(16'h0EDB, 3, 0);
    check("reset_mid.pulses", 32'(pulses), 32'd0);

    // Config load after 8 of 12 bits
    load(16'h0EDB, 12, 1'b1);
    feed_bits(16'h0EDB, 11, 4);
    load(16'h0EDB, 12, 1'b1);
    feed_bits(16'h0EDB, 3, 0);
    check("load_mid.pulses", 32'(pulses), 32'd0);
    feed_bits(16'h0EDB, 11, 0);
    check("load_mid.after", 32'(pulses), 32'd1);

    // Oversized length clamps to MAX_LEN
    load(16'hA5C3, 20, 1'b0);
    feed_bits(16'hA5C3, 15, 0);
    check("clamp.pulses", 32'(pulses), 32'd1);

    // Randomized configurations and streams
    for (int c = 0; c < 8; c++) begin
      load(16'($urandom), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 80; i++)
        cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
